hazard_controller: RTL and testbench

//  Pipeline sequencer for the LAPI DOpaCA LAMBA core; sits beside control_unit and the pipeline registers.

---
 rtl/hazard_controller_if.sv | 39 +++
 rtl/hazard_controller.sv | 149 ++++++++++++++
 tb/tb_hazard_controller.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_controller_if.sv
// Hazard-detection inputs from the pipeline and the sequencing controls returned to it.
// master = hazard_controller side, slave = pipeline/control_unit side.
interface hazard_controller_if #(
  parameter int REG_ADDR_W = 4
);
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rt;
  logic                  id_is_jump;
  logic                  ex_is_load;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  mem_branch_taken;
  logic                  mem_req;
  logic                  mem_ready;

  logic                  stall_pipeline;
  logic                  pc_write_enable;
  logic                  if_id_write_enable;
  logic                  ex_mem_write_enable;
  logic                  if_id_flush;
  logic                  id_ex_flush;
  logic                  ex_mem_flush;
  logic                  pc_sel_branch;
  logic                  core_halted;

  modport master (
    input  id_rs, id_rt, id_uses_rt, id_is_jump, ex_is_load, ex_rd,
           mem_branch_taken, mem_req, mem_ready,
    output stall_pipeline, pc_write_enable, if_id_write_enable, ex_mem_write_enable,
           if_id_flush, id_ex_flush, ex_mem_flush, pc_sel_branch, core_halted
  );

  modport slave (
    output id_rs, id_rt, id_uses_rt, id_is_jump, ex_is_load, ex_rd,
           mem_branch_taken, mem_req, mem_ready,
    input  stall_pipeline, pc_write_enable, if_id_write_enable, ex_mem_write_enable,
           if_id_flush, id_ex_flush, ex_mem_flush, pc_sel_branch, core_halted
  );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline sequencer: load-use stalls, jump/branch flushes, memory-wait freeze with watchdog halt.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_controller #(
  parameter int REG_ADDR_W  = 4,
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic                clk,
  input  logic                rst,
  hazard_controller_if.master hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         flush_events,
  output logic [31:0]         memwait_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_HALT
  } state_t;

  // A timeout larger than the counter range can never be reached; the counter then just saturates.
  localparam bit WATCHDOG_ON =
      (MEM_TIMEOUT >= 1) && (longint'(MEM_TIMEOUT) <= (longint'(1) << TIMEOUT_W));
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] CNT_MAX  = '1;

  genvar gi;

  state_t                state_reg, state_next;
  logic [TIMEOUT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic                  mem_stall;
  logic                  load_use;
  logic [REG_ADDR_W-1:0] rs_eq_bits;
  logic [REG_ADDR_W-1:0] rt_eq_bits;

  for (gi = 0; gi < REG_ADDR_W; gi++) begin : g_addr_cmp
    assign rs_eq_bits[gi] = ~(hz.ex_rd[gi] ^ hz.id_rs[gi]);
    assign rt_eq_bits[gi] = ~(hz.ex_rd[gi] ^ hz.id_rt[gi]);
  end

  // r0 is deliberately not excluded: a load to r0 still stalls.
  assign load_use = hz.ex_is_load && ((&rs_eq_bits) || (hz.id_uses_rt && (&rt_eq_bits)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_RUN;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next                = state_reg;
    wait_cnt_next             = wait_cnt_reg;
    hz.stall_pipeline         = 1'b0;
    hz.pc_write_enable        = 1'b1;
    hz.if_id_write_enable     = 1'b1;
    hz.ex_mem_write_enable    = 1'b1;
    hz.if_id_flush            = 1'b0;
    hz.id_ex_flush            = 1'b0;
    hz.ex_mem_flush           = 1'b0;
    hz.pc_sel_branch          = 1'b0;

    // Once frozen, the access stays outstanding until ready regardless of mem_req.
    case (state_reg)
      ST_RUN:      mem_stall = hz.mem_req && !hz.mem_ready;
      ST_MEM_WAIT: mem_stall = !hz.mem_ready;
      default:     mem_stall = 1'b0;
    endcase

    if (state_reg == ST_HALT) begin
      hz.pc_write_enable     = 1'b0;
      hz.if_id_write_enable  = 1'b0;
      hz.ex_mem_write_enable = 1'b0;
    end else if (mem_stall) begin
      hz.pc_write_enable     = 1'b0;
      hz.if_id_write_enable  = 1'b0;
      hz.ex_mem_write_enable = 1'b0;
      if (WATCHDOG_ON && (wait_cnt_reg == CNT_LAST)) begin
        state_next = ST_HALT;
      end else begin
        state_next = ST_MEM_WAIT;
        if (wait_cnt_reg != CNT_MAX) begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
    end else begin
      state_next    = ST_RUN;
      wait_cnt_next = '0;
      if (hz.mem_branch_taken) begin
        // Everything younger than MEM is wrong-path, so its hazards are irrelevant.
        hz.pc_sel_branch = 1'b1;
        hz.if_id_flush   = 1'b1;
        hz.id_ex_flush   = 1'b1;
        hz.ex_mem_flush  = 1'b1;
      end else if (load_use) begin
        // Holding IF/ID keeps any jump in ID so it is acted on next cycle.
        hz.stall_pipeline     = 1'b1;
        hz.pc_write_enable    = 1'b0;
        hz.if_id_write_enable = 1'b0;
      end else if (hz.id_is_jump) begin
        hz.if_id_flush = 1'b1;
      end
    end

    if (rst) begin
      hz.stall_pipeline      = 1'b0;
      hz.pc_write_enable     = 1'b1;
      hz.if_id_write_enable  = 1'b1;
      hz.ex_mem_write_enable = 1'b1;
      hz.if_id_flush         = 1'b0;
      hz.id_ex_flush         = 1'b0;
      hz.ex_mem_flush        = 1'b0;
      hz.pc_sel_branch       = 1'b0;
    end
  end

  assign hz.core_halted = (state_reg == ST_HALT);

`ifdef HAZARD_PERF_EN
  logic [2:0] perf_inc;

  assign perf_inc = {state_reg == ST_MEM_WAIT,
                     hz.pc_sel_branch | hz.if_id_flush,
                     hz.stall_pipeline};

  for (gi = 0; gi < 3; gi++) begin : g_perf
    logic [31:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg <= '0;
      end else if (perf_inc[gi]) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
  end

  assign stall_cycles   = g_perf[0].cnt_reg;
  assign flush_events   = g_perf[1].cnt_reg;
  assign memwait_cycles = g_perf[2].cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed literal steps, then randomized traffic against a cycle model.
// Control outputs are packed as {stall, pc_we, if_id_we, ex_mem_we, if_id_fl, id_ex_fl, ex_mem_fl, pc_sel}.
module tb_hazard_controller;
  localparam int RW = 4;
  localparam int TW = 8;
  localparam int MT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_controller_if #(.REG_ADDR_W(RW)) hz();

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_events, memwait_cycles;
`endif

  hazard_controller #(
    .REG_ADDR_W (RW),
    .TIMEOUT_W  (TW),
    .MEM_TIMEOUT(MT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles  (stall_cycles),
    .flush_events  (flush_events),
    .memwait_cycles(memwait_cycles)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: outstanding access flag, length of the current wait run, halted flag.
  bit          m_frozen = 1'b0;
  int          m_wait   = 0;
  bit          m_halted = 1'b0;
  int unsigned m_stall_cnt = 0, m_flush_cnt = 0, m_memwait_cnt = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_vec();
    return {hz.stall_pipeline, hz.pc_write_enable, hz.if_id_write_enable, hz.ex_mem_write_enable,
            hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush, hz.pc_sel_branch};
  endfunction

  always @(negedge clk) begin
    logic [7:0] ev;
    bit         waiting;
    bit         n_frozen, n_halted;
    int         n_wait;
    n_frozen = m_frozen;
    n_halted = m_halted;
    n_wait   = m_wait;
    ev       = 8'b0111_0000;
    waiting  = 1'b0;
    if (rst) begin
      n_frozen = 1'b0;
      n_wait   = 0;
      n_halted = 1'b0;
    end else if (m_halted) begin
      ev = 8'b0000_0000;
    end else begin
      waiting = m_frozen ? !hz.mem_ready : (hz.mem_req && !hz.mem_ready);
      if (waiting) begin
        ev       = 8'b0000_0000;
        n_frozen = 1'b1;
        n_wait   = m_wait + 1;
        if (n_wait >= MT) n_halted = 1'b1;
      end else begin
        n_frozen = 1'b0;
        n_wait   = 0;
        if (hz.mem_branch_taken)
          ev = 8'b0111_1111;
        else if (hz.ex_is_load && (hz.ex_rd == hz.id_rs || (hz.id_uses_rt && hz.ex_rd == hz.id_rt)))
          ev = 8'b1001_0000;
        else if (hz.id_is_jump)
          ev = 8'b0111_1000;
      end
    end
    chk("model_ctl", dut_vec(), ev);
    chk("model_halt", hz.core_halted, m_halted);
`ifdef HAZARD_PERF_EN
    chk("model_stall_cnt", stall_cycles, m_stall_cnt);
    chk("model_flush_cnt", flush_events, m_flush_cnt);
    chk("model_memwait_cnt", memwait_cycles, m_memwait_cnt);
`endif
    if (rst) begin
      m_stall_cnt = 0; m_flush_cnt = 0; m_memwait_cnt = 0;
    end else begin
      if (ev[7]) m_stall_cnt++;
      if (ev[0] || ev[3]) m_flush_cnt++;
      if (m_frozen && !m_halted) m_memwait_cnt++;
    end
    m_frozen = n_frozen;
    m_wait   = n_wait;
    m_halted = n_halted;
  end

  task automatic drive(input logic [3:0] rs, input logic [3:0] rt, input logic uses_rt,
                       input logic jump, input logic load, input logic [3:0] rd,
                       input logic br, input logic req, input logic rdy);
    hz.id_rs = rs; hz.id_rt = rt; hz.id_uses_rt = uses_rt; hz.id_is_jump = jump;
    hz.ex_is_load = load; hz.ex_rd = rd; hz.mem_branch_taken = br;
    hz.mem_req = req; hz.mem_ready = rdy;
  endtask

  task automatic idle();
    drive(4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic step(string name, logic [7:0] exp_vec, bit chk_halt, logic exp_halt);
    @(negedge clk);
    chk({name, "/ctl"}, dut_vec(), exp_vec);
    if (chk_halt) chk({name, "/halt"}, hz.core_halted, exp_halt);
    $display("step %-10s ctl=%b halted=%b", name, dut_vec(), hz.core_halted);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step("reset0", 8'b0111_0000, 1, 1'b0);
    step("reset1", 8'b0111_0000, 1, 1'b0);
    rst = 1'b0;
    step("idle", 8'b0111_0000, 1, 1'b0);

    drive(4'd3, 4'd9, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
    step("lu_rs", 8'b1001_0000, 1, 1'b0);
    drive(4'd3, 4'd9, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    step("lu_after", 8'b0111_0000, 1, 1'b0);
    drive(4'd1, 4'd5, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1);
    step("lu_nort", 8'b0111_0000, 1, 1'b0);
    drive(4'd1, 4'd5, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1);
    step("lu_rt", 8'b1001_0000, 1, 1'b0);
    drive(4'd0, 4'd6, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
    step("lu_r0", 8'b1001_0000, 1, 1'b0);
    drive(4'd3, 4'd9, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1);
    step("br_lu", 8'b0111_1111, 1, 1'b0);
    drive(4'd1, 4'd2, 1'b0, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1);
    step("jump", 8'b0111_1000, 1, 1'b0);
    drive(4'd4, 4'd2, 1'b0, 1'b1, 1'b1, 4'd4, 1'b0, 1'b0, 1'b1);
    step("jmp_lu", 8'b1001_0000, 1, 1'b0);

    // Memory wait outranks a taken branch; on completion the branch acts.
    for (int i = 0; i < 3; i++) begin
      drive(4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b1, 1'b0);
      step("mw", 8'b0000_0000, 1, 1'b0);
    end
    drive(4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b1, 1'b1);
    step("mw_done", 8'b0111_1111, 1, 1'b0);
    idle();
    step("idle2", 8'b0111_0000, 1, 1'b0);

    // Watchdog: MT wait cycles, then sticky halt even once ready arrives.
    for (int i = 0; i < MT; i++) begin
      drive(4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 1'b1, 1'b0);
      step("wd_wait", 8'b0000_0000, 1, 1'b0);
    end
    step("halted", 8'b0000_0000, 1, 1'b1);
    idle();
    step("halted_rdy", 8'b0000_0000, 1, 1'b1);
    rst = 1'b1;
    step("rst_halt", 8'b0111_0000, 0, 1'b0);
    rst = 1'b0;
    step("halt_clr", 8'b0111_0000, 1, 1'b0);

    // Reset in the middle of a wait must clear the wait count.
    for (int i = 0; i < 2; i++) begin
      drive(4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 1'b1, 1'b0);
      step("pre_rst_w", 8'b0000_0000, 1, 1'b0);
    end
    rst = 1'b1;
    step("rst_wait", 8'b0111_0000, 1, 1'b0);
    rst = 1'b0;
    idle();
    @(negedge clk);
`ifdef HAZARD_PERF_EN
    chk("perf_stall_zero", stall_cycles, 32'd0);
    chk("perf_flush_zero", flush_events, 32'd0);
    chk("perf_memwait_zero", memwait_cycles, 32'd0);
`endif
    chk("post_rst/ctl", dut_vec(), 8'b0111_0000);
    @(posedge clk);
    #1;
    for (int i = 0; i < MT - 1; i++) begin
      drive(4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 1'b1, 1'b0);
      step("post_rst_w", 8'b0000_0000, 1, 1'b0);
    end
    drive(4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 1'b1, 1'b1);
    step("post_rst_ok", 8'b0111_0000, 1, 1'b0);

    // Randomized traffic; the model process checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      drive(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom),
            ($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom_range(0, 3)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 9) < 6));
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
